// File: rtl/zircon_tlc5615_spi_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// zircon_tlc5615_pkg
//
// Shared definitions for the TLC5615 serial sequencer:
//   state_e      - sequencer states (IDLE, SETUP, SHIFT, HOLD)
//   FRAME_BITS   - bits per TLC5615 serial frame
//   HALF_PERIODS - SCLK half-periods per frame (two per bit)
//   build_frame  - maps an 8-bit DAC code onto the 16-bit wire frame
// -----------------------------------------------------------------------------
package zircon_tlc5615_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int FRAME_BITS   = 16;
    localparam int HALF_PERIODS = 32;

    // Four dummy bits lead the frame. The 8-bit code fills the upper bits of
    // the 10-bit DAC word, whose two LSBs are zero. Two fill bits close the
    // frame, so the code sits in bits [11:4].
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] code);
        return {4'h0, code, 4'h0};
    endfunction

endpackage

// File: rtl/zircon_tlc5615_spi_ctrl_if.sv
// -----------------------------------------------------------------------------
// zircon_tlc5615_spi_ctrl_if
//
// Bundles the register-block request/status signals and the TLC5615 pins.
//   da_in[7:0]   DAC code, sampled when da_start is high
//   da_start     one-cycle request pulse
//   da_busy      frame, CS hold or pending request outstanding
//   da_done      one-cycle pulse when a frame's CS hold completes
//   da_overrun   one-cycle pulse when an unsent pending code is overwritten
//   tlc_cs_n     DAC chip select, active-low
//   tlc_sclk     DAC serial clock
//   tlc_din      DAC serial data, MSB first
// The master modport is the register block, which drives requests and may
// observe the pins. The slave modport is the sequencer.
// -----------------------------------------------------------------------------
interface zircon_tlc5615_spi_ctrl_if;

    logic [7:0] da_in;
    logic       da_start;
    logic       da_busy;
    logic       da_done;
    logic       da_overrun;
    logic       tlc_cs_n;
    logic       tlc_sclk;
    logic       tlc_din;

    modport master (
        output da_in, da_start,
        input  da_busy, da_done, da_overrun,
        input  tlc_cs_n, tlc_sclk, tlc_din
    );

    modport slave (
        input  da_in, da_start,
        output da_busy, da_done, da_overrun,
        output tlc_cs_n, tlc_sclk, tlc_din
    );

endinterface

// File: rtl/zircon_tlc5615_clkdiv.sv
// -----------------------------------------------------------------------------
// zircon_tlc5615_clkdiv
//
// Tick generator. tick_o is high on the last cycle of each CLK_DIV-cycle
// interval. The interval restarts whenever clear_i is high, which the
// sequencer asserts on every state entry.
//   clk_i    system clock
//   rst_i    asynchronous active-high reset
//   clear_i  restart the interval next cycle
//   tick_o   last cycle of the current interval
// -----------------------------------------------------------------------------
module zircon_tlc5615_clkdiv #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int              CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves it unassigned would infer a latch.
        cnt_d = cnt_q + CW'(1);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignment so that every
        // flop samples the pre-edge values, independent of process order.
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/zircon_tlc5615_spi_ctrl.sv
// -----------------------------------------------------------------------------
// zircon_tlc5615_spi_ctrl
//
// Turns one-cycle da_start / da_in requests into 16-bit TLC5615 serial
// frames and buffers one request while a frame is in flight.
//   csi_clk    system clock
//   rsi_reset  asynchronous active-high reset
//   da_if      slave side of zircon_tlc5615_spi_ctrl_if (request, status
//              and the DAC pins; all outputs come straight from flops)
// Parameters:
//   CLK_DIV    SCLK half-period in csi_clk cycles (2..255)
//   CS_HOLD    minimum CS-high cycles between frames (1..255)
//
// Frame timeline for a request sampled at edge N with D = CLK_DIV:
//   SETUP  D cycles, CS low, SCLK low, DIN = bit15
//   SHIFT  32 half-periods of D cycles. The first half-period is high.
//          DIN advances at the start of each low half.
//   HOLD   CS_HOLD cycles with CS high. da_done is seen with the IDLE return.
// -----------------------------------------------------------------------------
module zircon_tlc5615_spi_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int CS_HOLD = 2
) (
    input  logic                            csi_clk,
    input  logic                            rsi_reset,
    zircon_tlc5615_spi_ctrl_if.slave        da_if
);

    import zircon_tlc5615_pkg::*;

    localparam logic [5:0] HALF_LAST = 6'(HALF_PERIODS - 1);
    localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD - 1);

    state_e                 state_q,      state_d;
    logic [FRAME_BITS-1:0]  shreg_q,      shreg_d;
    logic [5:0]             half_cnt_q,   half_cnt_d;
    logic [7:0]             hold_cnt_q,   hold_cnt_d;
    logic [7:0]             pend_code_q,  pend_code_d;
    logic                   pend_valid_q, pend_valid_d;
    logic                   sclk_q,       sclk_d;
    logic                   cs_n_q,       cs_n_d;
    logic                   busy_q,       busy_d;
    logic                   done_q,       done_d;
    logic                   overrun_q,    overrun_d;

    logic                   tick;
    logic                   state_entry;

    // Restarting the divider on every state change aligns SETUP and the
    // first SHIFT half-period to the transition edge.
    assign state_entry = (state_d != state_q);

    zircon_tlc5615_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .clk_i   (csi_clk),
        .rst_i   (rsi_reset),
        .clear_i (state_entry),
        .tick_o  (tick)
    );

    // ---------------------------------------------------------------------
    // Next-state and output decode
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        half_cnt_d   = half_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        pend_code_d  = pend_code_q;
        pend_valid_d = pend_valid_q;
        sclk_d       = sclk_q;
        done_d       = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    // The older buffered request goes first. A start in the
                    // same cycle refills the buffer that is being emptied.
                    state_d      = ST_SETUP;
                    shreg_d      = build_frame(pend_code_q);
                    pend_valid_d = 1'b0;
                    if (da_if.da_start) begin
                        pend_code_d  = da_if.da_in;
                        pend_valid_d = 1'b1;
                    end
                end else if (da_if.da_start) begin
                    state_d = ST_SETUP;
                    shreg_d = build_frame(da_if.da_in);
                end
            end

            ST_SETUP: begin
                if (tick) begin
                    state_d    = ST_SHIFT;
                    sclk_d     = 1'b1;
                    half_cnt_d = '0;
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    if (half_cnt_q == HALF_LAST) begin
                        state_d    = ST_HOLD;
                        sclk_d     = 1'b0;
                        hold_cnt_d = '0;
                    end else begin
                        half_cnt_d = half_cnt_q + 6'd1;
                        sclk_d     = ~sclk_q;
                        // A falling SCLK opens a low half, so the next bit is
                        // presented here. Zero fill leaves DIN low after bit0.
                        if (sclk_q) begin
                            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outside IDLE a request can only be buffered. The newest code wins.
        if (da_if.da_start && (state_q != ST_IDLE)) begin
            pend_code_d  = da_if.da_in;
            pend_valid_d = 1'b1;
            overrun_d    = pend_valid_q;
        end

        // Pin levels are decoded from the next state so the flops present
        // them in the same cycle as the state they belong to.
        cs_n_d = !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
        busy_d = (state_d != ST_IDLE) || pend_valid_d;
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            half_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            // NOTE: the pending code is qualified by pend_valid_q and needs
            // no reset. It is cleared anyway because it is a single small
            // register, and a known value keeps simulation free of X.
            pend_code_q  <= '0;
            pend_valid_q <= 1'b0;
            sclk_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            half_cnt_q   <= half_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            pend_code_q  <= pend_code_d;
            pend_valid_q <= pend_valid_d;
            sclk_q       <= sclk_d;
            cs_n_q       <= cs_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign da_if.tlc_cs_n   = cs_n_q;
    assign da_if.tlc_sclk   = sclk_q;
    assign da_if.tlc_din    = shreg_q[FRAME_BITS-1];
    assign da_if.da_busy    = busy_q;
    assign da_if.da_done    = done_q;
    assign da_if.da_overrun = overrun_q;

endmodule

// File: tb/tb_zircon_tlc5615_spi_ctrl.sv
// -----------------------------------------------------------------------------
// tb_zircon_tlc5615_spi_ctrl
//
// Directed bench. Instance A uses CLK_DIV=4 and CS_HOLD=2. Instance B uses
// CLK_DIV=2 and CS_HOLD=1. A negedge SPI monitor rebuilds each frame from
// the pins and records the CS-low length, the preceding CS-high gap, the
// SCLK half-period lengths, DIN stability at SCLK rising edges, and the
// done and overrun pulses.
// -----------------------------------------------------------------------------
module tb_zircon_tlc5615_spi_ctrl;

    logic csi_clk;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;

    int   n_vec  = 0;
    int   n_miss = 0;

    zircon_tlc5615_spi_ctrl_if ifa ();
    zircon_tlc5615_spi_ctrl_if ifb ();

    zircon_tlc5615_spi_ctrl #(.CLK_DIV(4), .CS_HOLD(2)) dut_a (
        .csi_clk   (csi_clk),
        .rsi_reset (rst_a),
        .da_if     (ifa)
    );

    zircon_tlc5615_spi_ctrl #(.CLK_DIV(2), .CS_HOLD(1)) dut_b (
        .csi_clk   (csi_clk),
        .rsi_reset (rst_b),
        .da_if     (ifb)
    );

    initial begin
        csi_clk = 1'b0;
        forever #5 csi_clk = ~csi_clk;
    end

    always @(posedge csi_clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // SPI monitor
    // ---------------------------------------------------------------------
    typedef struct {
        int          d;
        logic [15:0] data;
        int          nbits;
        int          cs_len;
        int          gap;
    } rec_t;

    rec_t        frame_log[$];

    logic        prev_cs   [2];
    logic        prev_sclk [2];
    logic        prev_din  [2];
    logic [15:0] mon_sr    [2];
    int          nbits     [2];
    int          cs_len    [2];
    int          gap       [2];
    int          cur_gap   [2];
    int          run       [2];
    int          half_bad  [2] = '{0, 0};
    int          din_bad   [2] = '{0, 0};
    int          done_cnt  [2] = '{0, 0};
    int          done_cyc  [2] = '{0, 0};
    logic        done_busy [2];
    int          ovr_cnt   [2] = '{0, 0};
    int          ovr_cyc   [2] = '{0, 0};

    task automatic mon_step(input int d, input int div, input logic rst,
                            input logic cs_n, input logic sclk, input logic din,
                            input logic busy, input logic done, input logic ovr);
        rec_t r;
        if (rst) begin
            prev_cs[d]   = 1'b1;
            prev_sclk[d] = 1'b0;
            prev_din[d]  = 1'b0;
            mon_sr[d]    = '0;
            nbits[d]     = 0;
            cs_len[d]    = 0;
            gap[d]       = 0;
            cur_gap[d]   = 0;
            run[d]       = 0;
        end else begin
            if (sclk != prev_sclk[d]) begin
                if (run[d] != div) half_bad[d]++;
                if (sclk && (din != prev_din[d])) din_bad[d]++;
                if (sclk && !cs_n) begin
                    mon_sr[d] = {mon_sr[d][14:0], din};
                    nbits[d]++;
                end
                run[d] = 1;
            end else begin
                run[d]++;
            end
            if (!cs_n && prev_cs[d]) begin
                cur_gap[d] = gap[d];
                cs_len[d]  = 0;
                nbits[d]   = 0;
                run[d]     = 1;
            end
            if (!cs_n) cs_len[d]++;
            else       gap[d]++;
            if (cs_n && !prev_cs[d]) begin
                r.d      = d;
                r.data   = mon_sr[d];
                r.nbits  = nbits[d];
                r.cs_len = cs_len[d];
                r.gap    = cur_gap[d];
                frame_log.push_back(r);
                gap[d] = 1;
            end
            if (done) begin
                done_cnt[d]++;
                done_cyc[d]  = cyc;
                done_busy[d] = busy;
            end
            if (ovr) begin
                ovr_cnt[d]++;
                ovr_cyc[d] = cyc;
            end
            prev_cs[d]   = cs_n;
            prev_sclk[d] = sclk;
            prev_din[d]  = din;
        end
    endtask

    always @(negedge csi_clk) begin
        mon_step(0, 4, rst_a, ifa.tlc_cs_n, ifa.tlc_sclk, ifa.tlc_din,
                 ifa.da_busy, ifa.da_done, ifa.da_overrun);
        mon_step(1, 2, rst_b, ifb.tlc_cs_n, ifb.tlc_sclk, ifb.tlc_din,
                 ifb.da_busy, ifb.da_done, ifb.da_overrun);
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    // Pulses da_start for one sampling edge. Returns 1 time unit after the
    // following negedge, so cyc is then the index of the sampling edge.
    task automatic drive_start(input int d, input logic [7:0] code);
        if (d == 0) begin
            ifa.da_in    = code;
            ifa.da_start = 1'b1;
        end else begin
            ifb.da_in    = code;
            ifb.da_start = 1'b1;
        end
        @(negedge csi_clk);
        #1;
        ifa.da_start = 1'b0;
        ifb.da_start = 1'b0;
    endtask

    task automatic wait_idle(input int d, input string tag);
        int   n;
        logic b;
        n = 0;
        b = (d == 0) ? ifa.da_busy : ifb.da_busy;
        while (b && (n < 2000)) begin
            @(negedge csi_clk);
            n++;
            b = (d == 0) ? ifa.da_busy : ifb.da_busy;
        end
        check({tag, "_idle_timeout"}, 32'(b), 32'd0);
        repeat (3) @(negedge csi_clk);
        #1;
    endtask

    function automatic logic [31:0] pins_a();
        return 32'({ifa.tlc_cs_n, ifa.tlc_sclk, ifa.tlc_din,
                    ifa.da_busy, ifa.da_done, ifa.da_overrun});
    endfunction

    function automatic logic [31:0] pins_b();
        return 32'({ifb.tlc_cs_n, ifb.tlc_sclk, ifb.tlc_din,
                    ifb.da_busy, ifb.da_done, ifb.da_overrun});
    endfunction

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        int s;
        int s3;
        int d0;
        int o0;

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.da_in = 8'h00; ifa.da_start = 1'b0;
        ifb.da_in = 8'h00; ifb.da_start = 1'b0;

        repeat (3) @(negedge csi_clk);
        #1;
        check("rst_pins_a", pins_a(), 32'b100000);
        check("rst_pins_b", pins_b(), 32'b100000);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge csi_clk);
        #1;
        check("post_rst_pins_a", pins_a(), 32'b100000);
        check("post_rst_pins_b", pins_b(), 32'b100000);

        // Single write of 0xA5.
        frame_log.delete();
        d0 = done_cnt[0];
        o0 = ovr_cnt[0];
        drive_start(0, 8'hA5);
        s = cyc;
        check("t1_first_cycle", 32'({ifa.tlc_cs_n, ifa.da_busy, ifa.tlc_din, ifa.tlc_sclk}), 32'b0100);
        wait_idle(0, "t1");
        check("t1_nframes", 32'(frame_log.size()), 32'd1);
        if (frame_log.size() >= 1) begin
            check("t1_frame",  32'(frame_log[0].data),   32'h0A50);
            check("t1_nbits",  32'(frame_log[0].nbits),  32'd16);
            check("t1_cs_len", 32'(frame_log[0].cs_len), 32'd132);
        end
        check("t1_done_cnt",  32'(done_cnt[0] - d0), 32'd1);
        check("t1_done_lat",  32'(done_cyc[0] - s),  32'd134);
        check("t1_done_busy", 32'(done_busy[0]),     32'd0);
        check("t1_overrun",   32'(ovr_cnt[0] - o0),  32'd0);

        // Two requests ten cycles apart: the second waits in the buffer.
        frame_log.delete();
        d0 = done_cnt[0];
        o0 = ovr_cnt[0];
        drive_start(0, 8'h12);
        repeat (9) @(negedge csi_clk);
        drive_start(0, 8'h34);
        check("t2_busy_pending", 32'(ifa.da_busy), 32'd1);
        wait_idle(0, "t2");
        check("t2_nframes", 32'(frame_log.size()), 32'd2);
        if (frame_log.size() >= 2) begin
            check("t2_frame0", 32'(frame_log[0].data), 32'h0120);
            check("t2_frame1", 32'(frame_log[1].data), 32'h0340);
            check("t2_gap",    32'(frame_log[1].gap),  32'd3);
        end
        check("t2_done_cnt", 32'(done_cnt[0] - d0), 32'd2);
        check("t2_overrun",  32'(ovr_cnt[0] - o0),  32'd0);

        // Three requests inside one frame: the third overwrites the second.
        frame_log.delete();
        d0 = done_cnt[0];
        o0 = ovr_cnt[0];
        drive_start(0, 8'h01);
        repeat (19) @(negedge csi_clk);
        drive_start(0, 8'h02);
        repeat (19) @(negedge csi_clk);
        drive_start(0, 8'h03);
        s3 = cyc;
        wait_idle(0, "t3");
        check("t3_nframes", 32'(frame_log.size()), 32'd2);
        if (frame_log.size() >= 2) begin
            check("t3_frame0", 32'(frame_log[0].data), 32'h0010);
            check("t3_frame1", 32'(frame_log[1].data), 32'h0030);
        end
        check("t3_overrun_cnt", 32'(ovr_cnt[0] - o0), 32'd1);
        check("t3_overrun_cyc", 32'(ovr_cyc[0]),      32'(s3));
        check("t3_done_cnt",    32'(done_cnt[0] - d0), 32'd2);

        // Reset while bit 7 is on the wire, then a clean frame.
        frame_log.delete();
        drive_start(0, 8'hC3);
        repeat (70) @(negedge csi_clk);
        #1;
        check("t4_bits_before_rst", 32'(nbits[0]), 32'd9);
        rst_a = 1'b1;
        #1;
        check("t4_async_rst", 32'({ifa.tlc_cs_n, ifa.tlc_sclk, ifa.da_busy}), 32'b100);
        @(negedge csi_clk);
        check("t4_rst_next", pins_a(), 32'b100000);
        repeat (2) @(negedge csi_clk);
        rst_a = 1'b0;
        @(negedge csi_clk);
        #1;
        check("t4_no_partial", 32'(frame_log.size()), 32'd0);
        drive_start(0, 8'h5A);
        wait_idle(0, "t4");
        check("t4_nframes", 32'(frame_log.size()), 32'd1);
        if (frame_log.size() >= 1) begin
            check("t4_frame",  32'(frame_log[0].data),   32'h05A0);
            check("t4_cs_len", 32'(frame_log[0].cs_len), 32'd132);
        end

        // Request coincident with the last HOLD cycle.
        frame_log.delete();
        d0 = done_cnt[0];
        o0 = ovr_cnt[0];
        drive_start(0, 8'h77);
        s = cyc;
        repeat (133) @(negedge csi_clk);
        check("t6_in_hold", 32'({ifa.tlc_cs_n, ifa.da_busy}), 32'b11);
        drive_start(0, 8'h88);
        check("t6_first_done", 32'(done_cnt[0] - d0), 32'd1);
        check("t6_busy_at_done", 32'(done_busy[0]),   32'd1);
        check("t6_idle_cs", 32'(ifa.tlc_cs_n), 32'd1);
        @(negedge csi_clk);
        #1;
        check("t6_restart_cs", 32'(ifa.tlc_cs_n), 32'd0);
        wait_idle(0, "t6");
        check("t6_nframes", 32'(frame_log.size()), 32'd2);
        if (frame_log.size() >= 2) begin
            check("t6_frame0", 32'(frame_log[0].data), 32'h0770);
            check("t6_frame1", 32'(frame_log[1].data), 32'h0880);
            check("t6_gap",    32'(frame_log[1].gap),  32'd3);
        end
        check("t6_done_cnt", 32'(done_cnt[0] - d0), 32'd2);
        check("t6_done2_lat", 32'(done_cyc[0] - s), 32'd269);
        check("t6_overrun",  32'(ovr_cnt[0] - o0),  32'd0);

        check("a_half_periods", 32'(half_bad[0]), 32'd0);
        check("a_din_stable",   32'(din_bad[0]),  32'd0);

        // Fastest divider and shortest hold, all-ones code.
        frame_log.delete();
        d0 = done_cnt[1];
        drive_start(1, 8'hFF);
        s = cyc;
        wait_idle(1, "t5");
        check("t5_nframes", 32'(frame_log.size()), 32'd1);
        if (frame_log.size() >= 1) begin
            check("t5_frame",  32'(frame_log[0].data),   32'h0FF0);
            check("t5_nbits",  32'(frame_log[0].nbits),  32'd16);
            check("t5_cs_len", 32'(frame_log[0].cs_len), 32'd66);
        end
        check("t5_half_periods", 32'(half_bad[1]), 32'd0);
        check("t5_din_stable",   32'(din_bad[1]),  32'd0);
        check("t5_done_cnt",     32'(done_cnt[1] - d0), 32'd1);
        check("t5_done_lat",     32'(done_cyc[1] - s),  32'd67);
        check("t5_done_busy",    32'(done_busy[1]),     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
